adxl345_spi_responder: RTL and testbench
========================================

ADXL345_SPI_RESPONDER -- requirements
Module: adxl345_spi_responder

Interface
REQ-001 Parameter DEVID_VALUE, default 8'hE5; value returned when address 0x00 is read.
REQ-002 Parameter SYNC_STAGES, default 2; flop count of the SPI input synchronisers, minimum 2.
REQ-003 Port sys_clk, input, 1 bit; the single clock for all logic.
REQ-004 Port rst_n, input, 1 bit; reset, asynchronous assert, active-low.
REQ-005 Port spi_sclk, input, 1 bit; SPI clock from the initiator, mode 3 (CPOL=1, CPHA=1).
REQ-006 Port spi_cs, input, 1 bit; chip select from the initiator, active-low.
REQ-007 Port spi_mosi, input, 1 bit; serial data from the initiator, MSB first.
REQ-008 Port spi_miso, output, 1 bit; serial data to the initiator, MSB first.
REQ-009 Port spi_miso_oe, output, 1 bit; MISO drive enable, high only while chip select is low.
REQ-010 Port sample_valid, input, 1 bit; single-cycle strobe that loads x_in, y_in and z_in.
REQ-011 Ports x_in, y_in and z_in, each input, 16 bits; two's-complement axis samples.
REQ-012 Port measure_en, output, 1 bit; equals POWER_CTL bit 3.
REQ-013 Port data_format, output, 8 bits; the DATA_FORMAT register (0x31).
REQ-014 Port bw_rate, output, 8 bits; the BW_RATE register (0x2C).
REQ-015 Port txn_done, output, 1 bit; one-cycle pulse when chip select deasserts.

Function
REQ-016 The block SHALL synchronise spi_sclk, spi_cs and spi_mosi into sys_clk and detect their edges there; sys_clk SHALL be at least 8x the SCLK frequency.
REQ-017 The state machine SHALL have four states with these transitions:
- IDLE to CMD on the falling edge of chip select.
- CMD to RD or WR after the 8th SCLK rising edge; bit 7 of the command selects read (1) or write (0).
- Bit 6 of the command is MB (multi-byte); bits 5:0 are the start address.
- RD and WR return to IDLE on the rising edge of chip select, from any state.
REQ-018 The block SHALL sample MOSI on each detected SCLK rising edge.
REQ-019 The block SHALL update MISO on each detected SCLK falling edge; the MSB of a read byte is driven on the falling edge after the 8th command rising edge.
REQ-020 Read map:
- 0x00 returns DEVID_VALUE.
- 0x2C returns bw_rate, 0x2D returns POWER_CTL, 0x31 returns data_format.
- 0x32 to 0x37 return the snapshot bytes {x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8]}.
- Every other address returns 8'h00.
REQ-021 With MB=1, the address SHALL increment after each byte and wrap from 0x3F to 0x00; with MB=0, the address SHALL stay fixed.
REQ-022 sample_valid SHALL load the live sample registers.
REQ-023 On the falling edge of chip select, the live sample registers SHALL be copied to the snapshot; if sample_valid occurs in the same cycle, the new sample SHALL be copied.
REQ-024 A write byte SHALL commit on its 8th rising edge.
REQ-025 Only addresses 0x2C, 0x2D and 0x31 are writable; writes to any other address SHALL be ignored.
REQ-026 If chip select rises mid-byte, the partial byte SHALL be discarded and no register SHALL change.
REQ-027 While chip select is high: spi_miso_oe=0, spi_miso=0, and the bit counter is cleared.

Reset
REQ-028 While rst_n is low, the block SHALL be in this state:
- State = IDLE.
- spi_miso=0, spi_miso_oe=0, txn_done=0.
- bw_rate=8'h0A, POWER_CTL=8'h00 (so measure_en=0), data_format=8'h00.
- Live and snapshot sample registers = 0.
- Synchroniser flops preset to 1 (idle bus level).
REQ-029 If reset asserts mid-transaction, the transaction SHALL be aborted; after release, the block SHALL wait for a fresh falling edge of chip select.

Configuration
REQ-030 Macro ADXL_RESP_WRITE_EN, when defined, SHALL compile in the register writes of REQ-024 and REQ-025.
REQ-031 Without ADXL_RESP_WRITE_EN, every write SHALL be ignored, the registers SHALL hold their reset values, and the WR state SHALL only shift data.

Structure
REQ-032 Package adxl345_pkg SHALL hold:
- the register address constants;
- the register reset values;
- the DEVID constant;
- the state enum (IDLE, CMD, RD, WR).
REQ-033 The block SHALL instantiate one sub-module, spi_edge_sync (synchroniser plus rise/fall detection), once per SPI input.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Read of 0x00, MB=0 (command 0x80): MISO byte = 0xE5.
- Write 0x08 to 0x2D (command 0x2D): measure_en=1; then read of 0x2D returns 0x08.
- Load x=0x1234, y=0xFFF0, z=0x0100, then multi-byte read from 0x32 (command 0xF2): MISO bytes = 34 12 F0 FF 00 01.
- sample_valid asserted mid-transaction with x=0x5555: the current frame still returns 0x1234; the next frame returns 0x5555.
- Chip select raised after 4 bits of a write to 0x31: data_format unchanged, and txn_done pulses once.
- Multi-byte read from 0x3F for 2 bytes: MISO bytes = 00 E5 (wrap to 0x00).

Source files
------------

// File: rtl/adxl345_pkg.sv
// adxl345_pkg
//   Shared definitions for the ADXL345-style SPI responder: register
//   addresses, register reset values, the device ID constant and the
//   transaction state enum.
package adxl345_pkg;

  // Register map addresses (6-bit address field of the SPI command)
  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  // Register reset values
  localparam logic [7:0] BW_RATE_RST     = 8'h0A;
  localparam logic [7:0] POWER_CTL_RST   = 8'h00;
  localparam logic [7:0] DATA_FORMAT_RST = 8'h00;

  // Device ID returned from address 0x00
  localparam logic [7:0] DEVID_DEFAULT = 8'hE5;

  // Transaction state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync
//   Brings one asynchronous SPI line into the system clock domain through a
//   chain of STAGES flops and flags its rising and falling edges there.
//   All flops reset to 1, the idle level of SCLK, CS and MOSI, so no edge is
//   reported coming out of reset.
// Ports:
//   clk_i    - system clock
//   rst_n_i  - asynchronous active-low reset
//   async_i  - raw SPI line
//   sync_o   - synchronised level
//   rise_o   - one-cycle pulse on a 0->1 transition of sync_o
//   fall_o   - one-cycle pulse on a 1->0 transition of sync_o
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchroniser chain plus one extra flop holding the previous level
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/adxl345_spi_responder.sv
// adxl345_spi_responder
//   SPI mode-3 target emulating a subset of the ADXL345 register map.
//   SCLK, CS and MOSI are oversampled in sys_clk (at least 8x SCLK); MOSI is
//   captured on SCLK rising edges and MISO is updated on SCLK falling edges.
//   A command byte {R/W, MB, addr[5:0]} is followed by data bytes; with MB
//   set the address auto-increments and wraps 0x3F -> 0x00. Axis samples are
//   frozen into a snapshot when CS falls so a frame reads a coherent set.
// Configuration macro:
//   ADXL_RESP_WRITE_EN - when defined, writes to BW_RATE (0x2C), POWER_CTL
//   (0x2D) and DATA_FORMAT (0x31) take effect; otherwise all writes are
//   ignored and those registers keep their reset values.
// Ports:
//   sys_clk, rst_n        - system clock, asynchronous active-low reset
//   spi_sclk/cs/mosi      - SPI inputs from the initiator
//   spi_miso, spi_miso_oe - SPI data out and its drive enable
//   sample_valid, x/y/z_in- strobe and 16-bit axis samples
//   measure_en            - POWER_CTL bit 3
//   data_format, bw_rate  - register contents
//   txn_done              - one-cycle pulse when a transaction ends
module adxl345_spi_responder
  import adxl345_pkg::*;
#(
  parameter logic [7:0] DEVID_VALUE = DEVID_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic        sample_valid,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  output logic        measure_en,
  output logic [7:0]  data_format,
  output logic [7:0]  bw_rate,
  output logic        txn_done
);

  // A single-flop synchroniser is never acceptable; clamp to two
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic sclkLevel, sclkRise, sclkFall;
  logic csLevel, csRise, csFall;
  logic mosiLevel, mosiRise, mosiFall;
  logic unusedSync;

  spi_edge_sync #(.STAGES(STAGES)) u_sclk_sync (
    .clk_i(sys_clk), .rst_n_i(rst_n), .async_i(spi_sclk),
    .sync_o(sclkLevel), .rise_o(sclkRise), .fall_o(sclkFall)
  );

  spi_edge_sync #(.STAGES(STAGES)) u_cs_sync (
    .clk_i(sys_clk), .rst_n_i(rst_n), .async_i(spi_cs),
    .sync_o(csLevel), .rise_o(csRise), .fall_o(csFall)
  );

  spi_edge_sync #(.STAGES(STAGES)) u_mosi_sync (
    .clk_i(sys_clk), .rst_n_i(rst_n), .async_i(spi_mosi),
    .sync_o(mosiLevel), .rise_o(mosiRise), .fall_o(mosiFall)
  );

  assign unusedSync = sclkLevel ^ mosiRise ^ mosiFall;

  spi_state_e        state_q;
  logic [2:0]        bitCnt_q;
  logic [6:0]        rxShift_q;
  logic [7:0]        txShift_q;
  logic [5:0]        addr_q;
  logic              mb_q;
  logic              miso_q;
  logic              misoOe_q;
  logic              txnDone_q;
  logic              armed_q;
  logic [STAGES-1:0] flush_q;
  logic [7:0]        bwRate_q;
  logic [7:0]        powerCtl_q;
  logic [7:0]        dataFormat_q;
  logic [15:0]       liveX_q, liveY_q, liveZ_q;
  logic [15:0]       snapX_q, snapY_q, snapZ_q;

  logic [7:0] rxByte_d;
  logic [5:0] addrNext_d;
  logic [5:0] rdAddr_d;
  logic [7:0] rdData_d;
  logic       startTxn;

  // Byte as it will stand once the current MOSI bit is shifted in
  assign rxByte_d   = {rxShift_q, mosiLevel};
  assign addrNext_d = mb_q ? addr_q + 6'd1 : addr_q;
  // A new frame starts only from IDLE and only once the bus has been seen
  // idle after reset, so a CS held low through reset is not taken as a start
  assign startTxn   = csFall & armed_q & (state_q == IDLE);

  // Read mux: the command byte supplies the first address, later bytes
  // use the (possibly incremented) running address
  always_comb begin
    rdAddr_d = (state_q == CMD) ? rxByte_d[5:0] : addrNext_d;
    rdData_d = 8'h00;
    case (rdAddr_d)
      ADDR_DEVID:       rdData_d = DEVID_VALUE;
      ADDR_BW_RATE:     rdData_d = bwRate_q;
      ADDR_POWER_CTL:   rdData_d = powerCtl_q;
      ADDR_DATA_FORMAT: rdData_d = dataFormat_q;
      ADDR_DATAX0:      rdData_d = snapX_q[7:0];
      ADDR_DATAX1:      rdData_d = snapX_q[15:8];
      ADDR_DATAY0:      rdData_d = snapY_q[7:0];
      ADDR_DATAY1:      rdData_d = snapY_q[15:8];
      ADDR_DATAZ0:      rdData_d = snapZ_q[7:0];
      ADDR_DATAZ1:      rdData_d = snapZ_q[15:8];
      default:          rdData_d = 8'h00;
    endcase
  end

  // Transaction FSM with registered MISO, drive enable and done pulse.
  // Registers only change on the 8th rising edge of a byte, so a frame cut
  // short by CS leaves them untouched.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      rxShift_q    <= '0;
      txShift_q    <= '0;
      addr_q       <= '0;
      mb_q         <= 1'b0;
      miso_q       <= 1'b0;
      misoOe_q     <= 1'b0;
      txnDone_q    <= 1'b0;
      armed_q      <= 1'b0;
      flush_q      <= '0;
      bwRate_q     <= BW_RATE_RST;
      powerCtl_q   <= POWER_CTL_RST;
      dataFormat_q <= DATA_FORMAT_RST;
    end else begin
      txnDone_q <= 1'b0;
      flush_q   <= {flush_q[STAGES-2:0], 1'b1};
      if (csLevel) begin
        state_q  <= IDLE;
        bitCnt_q <= '0;
        miso_q   <= 1'b0;
        misoOe_q <= 1'b0;
        // Synchroniser contents are real samples once flush_q fills
        if (flush_q[STAGES-1]) begin
          armed_q <= 1'b1;
        end
        if (csRise && state_q != IDLE) begin
          txnDone_q <= 1'b1;
        end
      end else if (state_q == IDLE) begin
        if (startTxn) begin
          state_q  <= CMD;
          bitCnt_q <= '0;
          miso_q   <= 1'b0;
          misoOe_q <= 1'b1;
        end
      end else if (sclkRise) begin
        rxShift_q <= rxByte_d[6:0];
        bitCnt_q  <= bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              mb_q      <= rxByte_d[6];
              addr_q    <= rxByte_d[5:0];
              state_q   <= rxByte_d[7] ? RD : WR;
              txShift_q <= rdData_d;
            end
            RD: begin
              addr_q    <= addrNext_d;
              txShift_q <= rdData_d;
            end
            WR: begin
              addr_q <= addrNext_d;
`ifdef ADXL_RESP_WRITE_EN
              case (addr_q)
                ADDR_BW_RATE:     bwRate_q     <= rxByte_d;
                ADDR_POWER_CTL:   powerCtl_q   <= rxByte_d;
                ADDR_DATA_FORMAT: dataFormat_q <= rxByte_d;
                default: ;
              endcase
`endif
            end
            default: ;
          endcase
        end
      end else if (sclkFall && state_q == RD) begin
        miso_q    <= txShift_q[7];
        txShift_q <= {txShift_q[6:0], 1'b0};
      end
    end
  end

  // Live samples follow sample_valid; the snapshot is frozen at frame start,
  // taking a same-cycle new sample in preference to the live copy
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      liveX_q <= '0;
      liveY_q <= '0;
      liveZ_q <= '0;
      snapX_q <= '0;
      snapY_q <= '0;
      snapZ_q <= '0;
    end else begin
      if (sample_valid) begin
        liveX_q <= x_in;
        liveY_q <= y_in;
        liveZ_q <= z_in;
      end
      if (startTxn) begin
        snapX_q <= sample_valid ? x_in : liveX_q;
        snapY_q <= sample_valid ? y_in : liveY_q;
        snapZ_q <= sample_valid ? z_in : liveZ_q;
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = misoOe_q;
  assign txn_done    = txnDone_q;
  assign measure_en  = powerCtl_q[3];
  assign data_format = dataFormat_q;
  assign bw_rate     = bwRate_q;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// tb_adxl345_spi_responder
//   Directed bench for adxl345_spi_responder. An SPI mode-3 initiator is
//   modelled with tasks; expected MISO bytes are pushed into a scoreboard
//   queue before each frame and popped as each byte arrives. Expected
//   register values follow ADXL_RESP_WRITE_EN so the bench fits either build.
module tb_adxl345_spi_responder;

  localparam int HALF = 60;

`ifdef ADXL_RESP_WRITE_EN
  localparam bit WRITES_ON = 1'b1;
`else
  localparam bit WRITES_ON = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  logic        sys_clk;
  logic        rst_n;
  logic        spi_sclk;
  logic        spi_cs;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        sample_valid;
  logic [15:0] x_in, y_in, z_in;
  logic        measure_en;
  logic [7:0]  data_format;
  logic [7:0]  bw_rate;
  logic        txn_done;

  int   compared   = 0;
  int   mismatched = 0;
  int   txnCount   = 0;
  exp_t expQ[$];

  adxl345_spi_responder dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .spi_sclk(spi_sclk),
    .spi_cs(spi_cs),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .sample_valid(sample_valid),
    .x_in(x_in),
    .y_in(y_in),
    .z_in(z_in),
    .measure_en(measure_en),
    .data_format(data_format),
    .bw_rate(bw_rate),
    .txn_done(txn_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Count completed-transaction pulses
  always @(posedge sys_clk) begin
    if (txn_done === 1'b1) begin
      txnCount = txnCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Clock nbits bits of tx (MSB first) and return what MISO held at each
  // rising edge
  task automatic applyStimulus(input logic [7:0] tx, input int nbits,
                               output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_sclk = 1'b0;
      spi_mosi = tx[i];
      #HALF;
      spi_sclk = 1'b1;
      rx[i] = spi_miso;
      #HALF;
    end
  endtask

  task automatic beginFrame();
    spi_cs = 1'b0;
    #HALF;
  endtask

  task automatic endFrame();
    #HALF;
    spi_cs   = 1'b1;
    spi_mosi = 1'b1;
    #(4 * HALF);
  endtask

  task automatic pushExp(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic popAndCheck(input logic [7:0] rx);
    exp_t e;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL sb_underflow: observed=%h expected=<none>", rx);
    end else begin
      e = expQ.pop_front();
      checkOutput(e.tag, {8'h00, rx}, {8'h00, e.val});
    end
  endtask

  // Full read frame: command byte then nbytes data bytes checked against
  // the scoreboard
  task automatic readFrame(input logic [7:0] cmd, input int nbytes);
    logic [7:0] rx;
    beginFrame();
    checkOutput("miso_oe_active", {15'd0, spi_miso_oe}, 16'd1);
    applyStimulus(cmd, 8, rx);
    for (int k = 0; k < nbytes; k++) begin
      applyStimulus(8'h00, 8, rx);
      popAndCheck(rx);
    end
    endFrame();
  endtask

  task automatic writeFrame(input logic [7:0] cmd, input logic [7:0] data,
                            input int dataBits);
    logic [7:0] rx;
    beginFrame();
    applyStimulus(cmd, 8, rx);
    applyStimulus(data, dataBits, rx);
    endFrame();
  endtask

  // One-cycle sample_valid pulse, timed so it spans exactly one posedge
  task automatic loadSample(input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z);
    x_in = x;
    y_in = y;
    z_in = z;
    sample_valid = 1'b1;
    #10;
    sample_valid = 1'b0;
  endtask

  initial begin
    int txnBefore;
    logic [7:0] rx;

    rst_n        = 1'b0;
    spi_sclk     = 1'b1;
    spi_cs       = 1'b1;
    spi_mosi     = 1'b1;
    sample_valid = 1'b0;
    x_in         = '0;
    y_in         = '0;
    z_in         = '0;

    #23;
    checkOutput("rst_miso",        {15'd0, spi_miso},    16'd0);
    checkOutput("rst_miso_oe",     {15'd0, spi_miso_oe}, 16'd0);
    checkOutput("rst_txn_done",    {15'd0, txn_done},    16'd0);
    checkOutput("rst_measure_en",  {15'd0, measure_en},  16'd0);
    checkOutput("rst_bw_rate",     {8'd0, bw_rate},      16'h000A);
    checkOutput("rst_data_format", {8'd0, data_format},  16'h0000);
    rst_n = 1'b1;
    #80;

    // Device ID read, single byte
    pushExp("devid", 8'hE5);
    readFrame(8'h80, 1);
    checkOutput("idle_miso_oe", {15'd0, spi_miso_oe}, 16'd0);
    checkOutput("idle_miso",    {15'd0, spi_miso},    16'd0);

    // Write 0x08 to POWER_CTL then read it back
    writeFrame(8'h2D, 8'h08, 8);
    checkOutput("measure_en", {15'd0, measure_en}, {15'd0, WRITES_ON});
    pushExp("power_ctl_rd", WRITES_ON ? 8'h08 : 8'h00);
    readFrame(8'hAD, 1);

    // Multi-byte axis read
    loadSample(16'h1234, 16'hFFF0, 16'h0100);
    pushExp("x0", 8'h34);
    pushExp("x1", 8'h12);
    pushExp("y0", 8'hF0);
    pushExp("y1", 8'hFF);
    pushExp("z0", 8'h00);
    pushExp("z1", 8'h01);
    readFrame(8'hF2, 6);

    // New sample arriving mid-frame must not disturb the current snapshot
    pushExp("snap_old_x0", 8'h34);
    pushExp("snap_old_x1", 8'h12);
    beginFrame();
    applyStimulus(8'hF2, 8, rx);
    loadSample(16'h5555, 16'hFFF0, 16'h0100);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(8'h00, 8, rx);
      popAndCheck(rx);
    end
    endFrame();
    pushExp("snap_new_x0", 8'h55);
    pushExp("snap_new_x1", 8'h55);
    readFrame(8'hF2, 2);

    // Write to DATA_FORMAT aborted after 4 data bits
    txnBefore = txnCount;
    writeFrame(8'h31, 8'hFF, 4);
    checkOutput("abort_data_format", {8'd0, data_format}, 16'h0000);
    checkOutput("abort_txn_pulses", 16'(txnCount - txnBefore), 16'd1);
    checkOutput("abort_bw_rate", {8'd0, bw_rate}, 16'h000A);

    // Multi-byte read wrapping 0x3F -> 0x00
    pushExp("wrap_3f", 8'h00);
    pushExp("wrap_00", 8'hE5);
    readFrame(8'hFF, 2);

    checkOutput("sb_leftover", 16'(expQ.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
